// File: rtl/bus_pkg.sv
// Shared bus-wide definitions: arbiter FSM encoding and system bus widths
// used by masters, the address/data mux and slaves.
package bus_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int ADDR_WIDTH = 16;
   localparam int DATA_WIDTH = 32;

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbitration handshake between the masters (master modport) and the bus
// arbiter (slave modport). preempt exists only with BUS_ARB_PREEMPT_EN.
interface bus_arbiter_if #(
   parameter int NUM_MASTERS = 2
) ();
   localparam int MSEL_W = $clog2(NUM_MASTERS);

   logic [NUM_MASTERS-1:0] breq;
   logic [NUM_MASTERS-1:0] bgrant;
   logic [MSEL_W-1:0]      msel;
   logic                   bus_busy;

`ifdef BUS_ARB_PREEMPT_EN
   logic                   preempt;

   modport master (output breq, input bgrant, msel, bus_busy, preempt);
   modport slave  (input breq, output bgrant, msel, bus_busy, preempt);
`else
   modport master (output breq, input bgrant, msel, bus_busy);
   modport slave  (input breq, output bgrant, msel, bus_busy);
`endif

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests so the slot after
// `last` is bit 0, take the lowest set bit, rotate the index back.
module rr_pick #(
   parameter  int NUM_MASTERS = 2,
   localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [IDX_W-1:0]       last,
   output logic                   valid,
   output logic [IDX_W-1:0]       idx
);

   logic [2*NUM_MASTERS-1:0] req_dbl;
   logic [NUM_MASTERS-1:0]   rot;
   int                       base;
   int                       pos;
   int                       sum;

   // NOTE: every variable gets a value before any branch so no latch is inferred.
   always_comb begin
      req_dbl = {req, req} >> 0;
      base    = int'(last) + 1;
      if (base >= NUM_MASTERS) base = 0;
      req_dbl = {req, req} >> base;
      rot     = req_dbl[NUM_MASTERS-1:0];
      pos     = 0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (rot[i]) pos = i;
      end
      sum = base + pos;
      if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
      valid = |req;
      idx   = IDX_W'(sum);
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin system bus arbiter with registered one-hot grant and owner index.
// Optional grant-tenure timeout is compiled in with BUS_ARB_PREEMPT_EN.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter  int NUM_MASTERS = 2,
   parameter  int HOLD_LIMIT  = 16,
   localparam int MSEL_W      = $clog2(NUM_MASTERS)
) (
   input  logic          clk,
   input  logic          rstn,
   bus_arbiter_if.slave  bus
);

   if (NUM_MASTERS < 2 || HOLD_LIMIT < 1) begin : g_bad_params
      $error("bus_arbiter: NUM_MASTERS must be >= 2 and HOLD_LIMIT >= 1");
   end

   arb_state_t             state_q, state_d;
   logic [NUM_MASTERS-1:0] bgrant_q, bgrant_d;
   logic [MSEL_W-1:0]      msel_q, msel_d;
   logic [MSEL_W-1:0]      last_q, last_d;
   logic                   pick_valid;
   logic [MSEL_W-1:0]      pick_idx;

`ifdef BUS_ARB_PREEMPT_EN
   localparam int CNT_W = $clog2(HOLD_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_LIMIT);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             preempt_q, preempt_d;
`endif

   rr_pick #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_pick (
      .req   (bus.breq),
      .last  (last_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d  = state_q;
      bgrant_d = bgrant_q;
      msel_d   = msel_q;
      last_d   = last_q;
`ifdef BUS_ARB_PREEMPT_EN
      cnt_d     = cnt_q;
      preempt_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d  = GRANT;
               bgrant_d = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick_idx;
               msel_d   = pick_idx;
               last_d   = pick_idx;
`ifdef BUS_ARB_PREEMPT_EN
               cnt_d    = '0;
`endif
            end
         end
         GRANT: begin
            // Release always wins over a timeout in the same cycle.
            if (!bus.breq[msel_q]) begin
               state_d  = IDLE;
               bgrant_d = '0;
            end
`ifdef BUS_ARB_PREEMPT_EN
            else if (cnt_q == CNT_MAX && |(bus.breq & ~bgrant_q)) begin
               state_d   = IDLE;
               bgrant_d  = '0;
               preempt_d = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: begin
            state_d  = IDLE;
            bgrant_d = '0;
         end
      endcase
   end

   // NOTE: reset is sampled on the clock edge, matching the rest of the system.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= IDLE;
         bgrant_q <= '0;
         msel_q   <= '0;
         last_q   <= MSEL_W'(NUM_MASTERS - 1);
`ifdef BUS_ARB_PREEMPT_EN
         cnt_q     <= '0;
         preempt_q <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments keep every register updating from pre-edge values.
         state_q  <= state_d;
         bgrant_q <= bgrant_d;
         msel_q   <= msel_d;
         last_q   <= last_d;
`ifdef BUS_ARB_PREEMPT_EN
         cnt_q     <= cnt_d;
         preempt_q <= preempt_d;
`endif
      end
   end

   assign bus.bgrant   = bgrant_q;
   assign bus.msel     = msel_q;
   assign bus.bus_busy = |bgrant_q;
`ifdef BUS_ARB_PREEMPT_EN
   assign bus.preempt  = preempt_q;
`endif

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the single system bus among `NUM_MASTERS` master ports. It takes each master's `breq` and returns a one-hot `bgrant`. It also drives `msel`, which the address/data/control multiplexer uses to route the owning master's `addr`, `wdata`, `wen` and `ren` to the slaves. The arbiter sits between the masters and the bus mux and holds no data itself.

## Interface
- `NUM_MASTERS`, default 2: number of requesting masters, at least 2.
- `HOLD_LIMIT`, default 16: maximum grant tenure in cycles when preemption is compiled in; at least 1.
- `MSEL_W`, default `$clog2(NUM_MASTERS)`: width of `msel`; derived, not overridden.

- `clk`  in  1  clock; reset rstn, synchronous, active-low; clock clk.
- `rstn`  in  1  synchronous active-low reset.
- `breq`  in  NUM_MASTERS  per-master bus request, level-sensitive.
- `bgrant`  out  NUM_MASTERS  one-hot (or zero) grant, registered.
- `msel`  out  MSEL_W  index of current owner, registered; valid while `bus_busy`=1.
- `bus_busy`  out  1  high while any grant is asserted (`|bgrant`).
- `preempt`  out  1  one-cycle pulse when a grant is revoked by timeout; present only with `BUS_ARB_PREEMPT_EN`.

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT: one owner.
- Reset values:
  - state IDLE; `bgrant`=0, `msel`=0, `bus_busy`=0, `preempt`=0.
  - Last-owner pointer `last`=NUM_MASTERS-1, so master 0 wins first.
  - Tenure counter is 0.
- IDLE:
  - If `breq`≠0, pick the first requester scanning `last+1`, `last+2`, … with modulo-NUM_MASTERS wrap.
  - Set `bgrant[pick]`=1, `msel`=pick, `last`=pick, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - Hold while `breq[msel]`=1.
  - When `breq[msel]`=0, clear `bgrant` and return to IDLE.
  - The owner is released, never transferred directly: there is always ≥1 IDLE cycle between owners, which gives the mux a turnaround cycle.
- Requests from non-owners during GRANT are ignored until IDLE; no queueing.
- A master deasserting `breq` before it is granted simply loses arbitration; no memory of past requests.
- `bgrant` is never multi-hot. `msel` changes only on an IDLE→GRANT transition.
- Reset mid-tenure: the next edge with `rstn`=0 forces all reset values regardless of state.

## Timing
- Grant latency: `breq` high at edge t in IDLE gives `bgrant` high after edge t. Latency is 1 cycle.
- Release: owner `breq` low sampled at edge t gives `bgrant` low after edge t.
- Handover: the earliest next grant is after edge t+1, so there are 2 cycles from the owner's drop to the new grant.
- Masters drive bus signals only in cycles where their `bgrant`=1. `wen`/`ren` asserted in the last granted cycle complete normally.

## Configuration
- Macro: `BUS_ARB_PREEMPT_EN`.
- Defined:
  - The tenure counter, of width `$clog2(HOLD_LIMIT+1)`, clears on entering GRANT and increments each GRANT cycle, saturating at HOLD_LIMIT.
  - When the counter equals HOLD_LIMIT and any other `breq` bit is high, the grant is revoked: go to IDLE, `bgrant`=0, `preempt`=1 for 1 cycle.
  - `last` stays at the preempted owner, so that owner is lowest priority in the next pick.
  - With no competing request, the owner keeps the bus indefinitely.
  - Owner release and timeout in the same cycle count as a release; `preempt` stays 0.
- Undefined:
  - No counter and no `preempt` port; `HOLD_LIMIT` is ignored.
  - Tenure is unbounded.

## Structure
- Shared package `bus_pkg`:
  - `arb_state_t` enum {IDLE, GRANT}.
  - Bus-wide `ADDR_WIDTH`=16 and `DATA_WIDTH`=32 constants, used by masters, mux and slaves.
- Sub-module `rr_pick`: combinational rotate-priority-rotate picker.
  - Inputs: `req[NUM_MASTERS]`, `last`.
  - Outputs: `valid`, `idx`.
  - Reused by any future slave-side arbiter.
- `bus_arbiter` itself holds the FSM, `last`, `msel`/`bgrant` registers and the optional counter.

## Test plan
- Reset then `breq`=2'b11 held: `bgrant`=01 one cycle after the sample. After master 0 drops, 1 IDLE cycle, then `bgrant`=10, `msel`=1.
- Single requester: `breq`=2'b10 for 5 cycles then 0. `bgrant`=10 for exactly 5 cycles, shifted 1 cycle late; `bus_busy` mirrors it.
- Fairness, NUM_MASTERS=4: all `breq` high, each owner releases after 3 cycles. Grant order is 0,1,2,3,0 with a 1-cycle gap each.
- Reset mid-tenure: `rstn`=0 for one cycle while master 1 is owner. The following cycle has `bgrant`=0 and `msel`=0; the next pick starts at master 0.
- `BUS_ARB_PREEMPT_EN`, HOLD_LIMIT=4: master 0 holds `breq`, master 1 requests.
  - Master 0's grant lasts 5 cycles (counter values 0–4).
  - `preempt` pulses once, then master 1 is granted after the IDLE cycle.
  - With master 1 idle, master 0 keeps the grant more than 20 cycles with `preempt`=0.
- Illegal-state check: assertion that `bgrant` is always $onehot0 and `msel` is stable during GRANT, for every scenario.
